fifo_rd_serializer: RTL and testbench

Read-side consumer for the synchronous FIFOs in the NoC/DTU datapath. It pops DATA_WIDTH-wide words from a first-word-fall-through FIFO read port (rd_en / rdata / rempty) and emits them as a continuous stream of narrower OUT_WIDTH beats over a valid/ready handshake. It sits between a wide buffering FIFO and a narrow link or serial egress stage, and sustains one beat per cycle with no bubble between consecutive words.

---
 rtl/fifo_rd_serializer_pkg.sv | 24 ++
 rtl/fifo_ser_shreg.sv | 47 ++++
 rtl/fifo_rd_serializer.sv | 75 +++++++
 tb/tb_fifo_rd_serializer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_serializer_pkg.sv
// Shared types and parameter helpers for the FIFO read-side serializer.
// Word/beat ratio, counter width and parameter legality are derived here.
package fifo_rd_serializer_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic int calc_ratio(input int data_width, input int out_width);
    return data_width / out_width;
  endfunction

  function automatic int calc_cnt_width(input int data_width, input int out_width);
    int ratio;
    ratio = data_width / out_width;
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

  function automatic bit params_ok(input int data_width, input int out_width);
    return (out_width > 0) && (data_width % out_width == 0) && (data_width / out_width >= 2);
  endfunction

endpackage

// File: rtl/fifo_ser_shreg.sv
// Holds one FIFO word and presents it one OUT_WIDTH slice at a time.
// The beat counter wraps modulo RATIO, so it is back at 0 after the final beat.
module fifo_ser_shreg
  import fifo_rd_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 4,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [OUT_WIDTH-1:0]  slice,
  output logic                  last
);

  localparam int RATIO     = calc_ratio(DATA_WIDTH, OUT_WIDTH);
  localparam int CNT_WIDTH = calc_cnt_width(DATA_WIDTH, OUT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(RATIO - 1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_WIDTH-1:0]  cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      shreg <= load_data;
      cnt   <= '0;
    end else if (shift) begin
      // The slice just sent drops out of the emitting end.
      if (LSB_FIRST) shreg <= shreg >> OUT_WIDTH;
      else           shreg <= shreg << OUT_WIDTH;
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_WIDTH'(1);
    end
  end

  assign slice = LSB_FIRST ? shreg[OUT_WIDTH-1:0] : shreg[DATA_WIDTH-1 -: OUT_WIDTH];
  assign last  = (cnt == CNT_LAST);

endmodule

// File: rtl/fifo_rd_serializer.sv
// Pops words from a FWFT FIFO and streams them as narrow valid/ready beats.
// state    | meaning
// ST_IDLE  | no word held; pops the FIFO head as soon as it is non-empty
// ST_SHIFT | word held; beats presented, next word popped on the last handshake
module fifo_rd_serializer
  import fifo_rd_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 4,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  fifo_rempty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  fifo_rd_en_o,
  output logic                  out_valid_o,
  output logic [OUT_WIDTH-1:0]  out_data_o,
  output logic                  out_last_o,
  input  logic                  out_ready_i,
  input  logic                  flush_i,
  output logic                  busy_o
);

  if (!params_ok(DATA_WIDTH, OUT_WIDTH)) begin : g_param_check
    $error("fifo_rd_serializer: DATA_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
  end

  state_t state;
  logic   beat_last;
  logic   hs;
  logic   pop;
  logic   shift_en;

  assign out_valid_o = (state == ST_SHIFT);
  assign busy_o      = (state == ST_SHIFT);
  assign out_last_o  = beat_last;
  assign hs          = out_valid_o & out_ready_i;

  // Popping on the last handshake keeps the stream gap-free across words.
  assign pop = !reset_i && !flush_i && !fifo_rempty_i &&
               ((state == ST_IDLE) || (hs && beat_last));
  assign fifo_rd_en_o = pop;
  assign shift_en     = hs && !flush_i;

  fifo_ser_shreg #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .LSB_FIRST  (LSB_FIRST)
  ) u_shreg (
    .clk       (clk_i),
    .reset     (reset_i),
    .load      (pop),
    .shift     (shift_en),
    .clear     (flush_i),
    .load_data (fifo_rdata_i),
    .slice     (out_data_o),
    .last      (beat_last)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= ST_IDLE;
    end else if (flush_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (pop) state <= ST_SHIFT;
        ST_SHIFT: if (hs && beat_last && !pop) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Bench for fifo_rd_serializer: LSB-first and MSB-first instances share one FIFO model
// and are compared every cycle against a word/beat-index reference model.
module tb_fifo_rd_serializer;

  logic        clk = 1'b0;
  logic        reset, flush, ready, rempty;
  logic [15:0] rdata;
  logic        rd_en_l, valid_l, last_l, busy_l;
  logic        rd_en_m, valid_m, last_m, busy_m;
  logic [3:0]  data_l, data_m;

  always #5 clk = ~clk;

  fifo_rd_serializer #(.DATA_WIDTH(16), .OUT_WIDTH(4), .LSB_FIRST(1'b1)) dut (
    .clk_i(clk), .reset_i(reset), .fifo_rempty_i(rempty), .fifo_rdata_i(rdata),
    .fifo_rd_en_o(rd_en_l), .out_valid_o(valid_l), .out_data_o(data_l),
    .out_last_o(last_l), .out_ready_i(ready), .flush_i(flush), .busy_o(busy_l));

  fifo_rd_serializer #(.DATA_WIDTH(16), .OUT_WIDTH(4), .LSB_FIRST(1'b0)) dut_msb (
    .clk_i(clk), .reset_i(reset), .fifo_rempty_i(rempty), .fifo_rdata_i(rdata),
    .fifo_rd_en_o(rd_en_m), .out_valid_o(valid_m), .out_data_o(data_m),
    .out_last_o(last_m), .out_ready_i(ready), .flush_i(flush), .busy_o(busy_m));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] fifo_q[$];

  // Reference model: the held word and the index of the beat on offer.
  bit          m_known = 1'b0;
  bit          m_busy  = 1'b0;
  bit          m_zero  = 1'b0;
  logic [15:0] m_word  = '0;
  int          m_idx   = 0;

  logic [31:0] log_l, log_m;
  int          n_beats, n_pops;
  int          pop_cyc[$];
  int          hs_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] slice_of(input logic [15:0] w, input int i);
    return 4'(w >> (4 * i));
  endfunction

  task automatic clear_logs();
    log_l = '0; log_m = '0; n_beats = 0; n_pops = 0;
    pop_cyc.delete(); hs_cyc.delete();
  endtask

  task automatic step(input bit r, input bit f, input bit rs);
    bit          nonempty;
    bit          exp_pop;
    logic [15:0] head;
    nonempty = (fifo_q.size() > 0);
    head     = nonempty ? fifo_q[0] : 16'h0;
    ready = r; flush = f; reset = rs;
    rempty = !nonempty;
    rdata  = nonempty ? head : 16'($urandom);
    exp_pop = !rs && !f && nonempty && (!m_busy || (r && m_idx == 3));
    #4;
    if (m_known) begin
      check("valid",     32'(valid_l), 32'(m_busy));
      check("valid_msb", 32'(valid_m), 32'(m_busy));
      check("busy",      32'(busy_l),  32'(m_busy));
      check("busy_msb",  32'(busy_m),  32'(m_busy));
      check("rd_en",     32'(rd_en_l), 32'(exp_pop));
      check("rd_en_msb", 32'(rd_en_m), 32'(exp_pop));
      if (m_busy) begin
        check("data",     32'(data_l), 32'(slice_of(m_word, m_idx)));
        check("data_msb", 32'(data_m), 32'(slice_of(m_word, 3 - m_idx)));
        check("last",     32'(last_l), 32'(m_idx == 3));
        check("last_msb", 32'(last_m), 32'(m_idx == 3));
      end else if (m_zero) begin
        check("rst_data",     32'(data_l), 32'h0);
        check("rst_data_msb", 32'(data_m), 32'h0);
        check("rst_last",     32'(last_l), 32'h0);
        check("rst_last_msb", 32'(last_m), 32'h0);
      end
    end
    if (!rs && !f && m_busy && r) begin
      log_l = {log_l[27:0], data_l};
      log_m = {log_m[27:0], data_m};
      n_beats++;
      hs_cyc.push_back(cyc);
    end
    if (rd_en_l === 1'b1) begin
      n_pops++;
      pop_cyc.push_back(cyc);
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    if (rs) begin
      m_busy = 1'b0; m_idx = 0; m_zero = 1'b1;
      fifo_q.delete();
    end else if (f) begin
      m_busy = 1'b0; m_idx = 0;
    end else if (!m_busy) begin
      if (nonempty) begin
        m_busy = 1'b1; m_word = head; m_idx = 0; m_zero = 1'b0;
      end
    end else if (r) begin
      if (m_idx == 3) begin
        if (nonempty) begin
          m_word = head; m_idx = 0;
        end else begin
          m_busy = 1'b0; m_idx = 0;
        end
      end else begin
        m_idx++;
      end
    end
    m_known = 1'b1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    ready = 1'b0; flush = 1'b0; reset = 1'b1; rempty = 1'b1; rdata = '0;
    clear_logs();
    #1;
    step(0, 0, 1);
    step(0, 0, 1);
    check("reset_valid", 32'(valid_l), 32'h0);
    check("reset_busy",  32'(busy_l),  32'h0);
    check("reset_data",  32'(data_l),  32'h0);
    check("reset_last",  32'(last_l),  32'h0);
    check("reset_rd_en", 32'(rd_en_l), 32'h0);

    // Single word, ready held high
    clear_logs();
    fifo_q.push_back(16'hA5C3);
    repeat (6) step(1, 0, 0);
    check("t1_pops",    32'(n_pops),  32'd1);
    check("t1_nbeats",  32'(n_beats), 32'd4);
    check("t1_beats",   log_l, 32'h3C5A);
    check("t1_beats_m", log_m, 32'hA5C3);
    if (n_pops >= 1 && n_beats >= 4) begin
      check("t1_latency", 32'(hs_cyc[0] - pop_cyc[0]), 32'd1);
      check("t1_gapless", 32'(hs_cyc[3] - hs_cyc[0]), 32'd3);
    end
    check("t1_end_valid", 32'(valid_l), 32'h0);
    check("t1_end_busy",  32'(busy_l),  32'h0);

    // Two queued words, no bubble between them
    clear_logs();
    fifo_q.push_back(16'h1234);
    fifo_q.push_back(16'hABCD);
    repeat (10) step(1, 0, 0);
    check("t2_nbeats",  32'(n_beats), 32'd8);
    check("t2_beats",   log_l, 32'h4321DCBA);
    check("t2_beats_m", log_m, 32'h1234ABCD);
    check("t2_pops",    32'(n_pops), 32'd2);
    if (n_pops >= 2 && n_beats >= 8) begin
      check("t2_pop_on_last", 32'(pop_cyc[1]), 32'(hs_cyc[3]));
      check("t2_gapless",     32'(hs_cyc[7] - hs_cyc[0]), 32'd7);
    end

    // Back-pressure on beat 2
    clear_logs();
    fifo_q.push_back(16'hA5C3);
    step(1, 0, 0);
    step(1, 0, 0);
    repeat (3) begin
      check("t3_hold_data",  32'(data_l),  32'hC);
      check("t3_hold_valid", 32'(valid_l), 32'h1);
      check("t3_hold_last",  32'(last_l),  32'h0);
      step(0, 0, 0);
      check("t3_no_pop", 32'(rd_en_l), 32'h0);
    end
    repeat (4) step(1, 0, 0);
    check("t3_beats", log_l, 32'h3C5A);
    check("t3_pops",  32'(n_pops), 32'd1);

    // Flush after the first beat
    clear_logs();
    fifo_q.push_back(16'hA5C3);
    fifo_q.push_back(16'h0F0F);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    check("t4_flush_pops",  32'(n_pops),  32'd1);
    check("t4_flush_valid", 32'(valid_l), 32'h0);
    repeat (6) step(1, 0, 0);
    check("t4_nbeats",  32'(n_beats), 32'd5);
    check("t4_beats",   log_l, 32'h3F0F0);
    check("t4_beats_m", log_m, 32'hA0F0F);

    // Reset mid-word, then a fresh word
    clear_logs();
    fifo_q.push_back(16'h1357);
    fifo_q.push_back(16'h9BDF);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 1);
    check("t5_valid",    32'(valid_l), 32'h0);
    check("t5_valid_m",  32'(valid_m), 32'h0);
    check("t5_busy",     32'(busy_l),  32'h0);
    check("t5_data",     32'(data_l),  32'h0);
    check("t5_data_m",   32'(data_m),  32'h0);
    check("t5_last",     32'(last_l),  32'h0);
    check("t5_rd_en",    32'(rd_en_l), 32'h0);
    clear_logs();
    fifo_q.push_back(16'h2468);
    repeat (6) step(1, 0, 0);
    check("t5_beats",   log_l, 32'h8642);
    check("t5_beats_m", log_m, 32'h2468);

    // Randomized traffic against the model
    repeat (3000) begin
      if (fifo_q.size() < 8 && $urandom_range(0, 9) < 4)
        fifo_q.push_back(16'($urandom));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
